// File: rtl/inst_cache_sa.sv
// Set-associative instruction cache with word-serial line refill.
// Same-cycle tag lookup for the fetch side, per-set LRU, whole-cache flush.
module inst_cache_sa #(
  parameter int SET_BIT       = 4,
  parameter int LINE_WORD_BIT = 2,
  parameter int WAYS          = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_hit,
  output logic [31:0] fetch_data,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);
  localparam int SETS    = 1 << SET_BIT;
  localparam int WORDS   = 1 << LINE_WORD_BIT;
  localparam int OFF     = LINE_WORD_BIT + 2;
  localparam int TAG_LEN = 32 - SET_BIT - OFF;

  localparam logic IDLE   = 1'b0;
  localparam logic REFILL = 1'b1;

  logic [31:0]              data_q [WAYS][SETS][WORDS];
  logic [TAG_LEN-1:0]       tag_q  [WAYS][SETS];
  logic [SETS-1:0]          valid_q [WAYS];
  logic [SETS-1:0]          lru_q;
  logic                     state_q;
  logic [LINE_WORD_BIT-1:0] cnt_q;
  logic                     flush_pend_q;
  logic                     victim_q;
  logic [SET_BIT-1:0]       line_idx_q;
  logic [TAG_LEN-1:0]       line_tag_q;

  logic [TAG_LEN-1:0]       f_tag;
  logic [SET_BIT-1:0]       f_idx;
  logic [LINE_WORD_BIT-1:0] f_off;
  logic [WAYS-1:0]          way_hit;
  logic                     hit_any;
  logic                     hit_way;
  logic                     victim;
  logic                     last;

  assign f_tag = fetch_addr[31:SET_BIT+OFF];
  assign f_idx = fetch_addr[SET_BIT+OFF-1:OFF];
  assign f_off = fetch_addr[OFF-1:2];
  assign busy  = (state_q == REFILL);
  assign last  = &cnt_q;

  // Descending scan so the lowest-index invalid way wins the victim pick.
  always_comb begin
    way_hit = '0;
    hit_way = 1'b0;
    victim  = (WAYS > 1) ? lru_q[f_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_hit[w] = valid_q[w][f_idx] && (tag_q[w][f_idx] == f_tag);
      if (way_hit[w])
        hit_way = 1'(w);
      if (!valid_q[w][f_idx])
        victim = 1'(w);
    end
  end

  assign hit_any   = |way_hit;
  assign fetch_hit = rdy_in & fetch_valid & (state_q == IDLE)
                   & hit_any & ~flush;
  assign fetch_data = fetch_hit ? data_q[hit_way][f_idx][f_off] : '0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int w = 0; w < WAYS; w++)
        valid_q[w] <= '0;
      lru_q        <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      victim_q     <= 1'b0;
      line_idx_q   <= '0;
      line_tag_q   <= '0;
    end else if (rdy_in) begin
      if (fetch_hit && WAYS > 1)
        lru_q[f_idx] <= ~hit_way;
      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int w = 0; w < WAYS; w++)
              valid_q[w] <= '0;
          end else if (fetch_valid && !hit_any) begin
            state_q    <= REFILL;
            mem_req    <= 1'b1;
            mem_addr   <= {fetch_addr[31:OFF], {OFF{1'b0}}};
            cnt_q      <= '0;
            victim_q   <= victim;
            line_idx_q <= f_idx;
            line_tag_q <= f_tag;
          end
        end
        REFILL: begin
          if (flush) begin
            for (int w = 0; w < WAYS; w++)
              valid_q[w] <= '0;
            flush_pend_q <= 1'b1;
          end
          if (mem_ack) begin
            cnt_q    <= cnt_q + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (last) begin
              valid_q[victim_q][line_idx_q] <= ~(flush_pend_q | flush);
              if (WAYS > 1)
                lru_q[line_idx_q] <= ~victim_q;
              mem_req      <= 1'b0;
              cnt_q        <= '0;
              flush_pend_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset; valid bits guard every read.
  always_ff @(posedge clk_in) begin
    if (rdy_in && state_q == REFILL && mem_ack) begin
      data_q[victim_q][line_idx_q][cnt_q] <= mem_data;
      if (last)
        tag_q[victim_q][line_idx_q] <= line_tag_q;
    end
  end

endmodule

// File: tb/tb_inst_cache_sa.sv
// Bench for inst_cache_sa: per-scenario tasks against a
// recency-list residency model and a hashed memory image.
module tb_inst_cache_sa;
  localparam int WAYS  = 2;
  localparam int WORDS = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_hit;
  logic [31:0] fetch_data;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] seed;

  // Per set: resident line base addresses, most recent first.
  logic [31:0] res [16][$];

  inst_cache_sa #(.SET_BIT(4), .LINE_WORD_BIT(2), .WAYS(WAYS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_hit(fetch_hit), .fetch_data(fetch_data),
    .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++)
      res[s].delete();
  endtask

  function automatic int model_find(input int s, input logic [31:0] b);
    for (int i = 0; i < res[s].size(); i++)
      if (res[s][i] == b)
        return i;
    return -1;
  endfunction

  task automatic refill(input logic [31:0] base, input int flush_after,
                        input int stall_after, output bit fl);
    fl = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      int wt;
      wt = $urandom_range(0, 2);
      for (int k = 0; k < wt; k++)
        tick();
      n_chk++;
      if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== base + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL refill_req w%0d: req=%b busy=%b addr=%h expected req=1 busy=1 addr=%h",
                 i, mem_req, busy, mem_addr, base + 32'(4 * i));
      end
      mem_ack  = 1'b1;
      mem_data = mem_word(base + 32'(4 * i));
      if (i == stall_after) begin
        rdy_in      = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = base;
        for (int k = 0; k < 3; k++) begin
          #1;
          n_chk++;
          if (mem_addr !== base + 32'(4 * i) || fetch_hit !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall c%0d: addr=%h hit=%b req=%b expected addr=%h hit=0 req=1",
                     k, mem_addr, fetch_hit, mem_req, base + 32'(4 * i));
          end
          tick();
        end
        rdy_in      = 1'b1;
        fetch_valid = 1'b0;
      end
      tick();
      mem_ack = 1'b0;
      if (i + 1 == flush_after) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fl    = 1'b1;
      end
    end
    n_chk++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_done: busy=%b req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic fetch_x(input logic [31:0] a, input int fa, input int sa);
    logic [31:0] base;
    int s;
    int pos;
    bit fl;
    base = {a[31:4], 4'b0};
    s    = int'(a[7:4]);
    pos  = model_find(s, base);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    #1;
    n_chk++;
    if (pos >= 0) begin
      if (fetch_hit !== 1'b1 || fetch_data !== mem_word({a[31:2], 2'b0})) begin
        n_fail++;
        $display("FAIL fetch_hit %h: hit=%b data=%h expected hit=1 data=%h",
                 a, fetch_hit, fetch_data, mem_word({a[31:2], 2'b0}));
      end
      tick();
      fetch_valid = 1'b0;
      res[s].delete(pos);
      res[s].push_front(base);
    end else begin
      if (fetch_hit !== 1'b0 || fetch_data !== 32'h0) begin
        n_fail++;
        $display("FAIL fetch_miss %h: hit=%b data=%h expected hit=0 data=0",
                 a, fetch_hit, fetch_data);
      end
      tick();
      fetch_valid = 1'b0;
      n_chk++;
      if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== base) begin
        n_fail++;
        $display("FAIL miss_start %h: busy=%b req=%b addr=%h expected 1 1 %h",
                 a, busy, mem_req, mem_addr, base);
      end
      refill(base, fa, sa, fl);
      if (fl) begin
        model_clear();
      end else begin
        res[s].push_front(base);
        if (res[s].size() > WAYS)
          void'(res[s].pop_back());
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_x(a, -1, -1);
  endtask

  task automatic probe(input logic [31:0] a, input logic exp, input string nm);
    fetch_addr  = a;
    fetch_valid = 1'b1;
    #1;
    n_chk++;
    if (fetch_hit !== exp) begin
      n_fail++;
      $display("FAIL %s: fetch_hit=%b expected %b", nm, fetch_hit, exp);
    end
    fetch_valid = 1'b0;
    tick();
  endtask

  task automatic flush_idle(input logic [31:0] a);
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    #1;
    n_chk++;
    if (fetch_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_hit: fetch_hit=%b expected 0", fetch_hit);
    end
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    n_chk++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_req: req=%b busy=%b expected 0 0", mem_req, busy);
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h1000;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = '0;
    #2;
    n_chk++;
    if (fetch_hit !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: hit=%b req=%b busy=%b addr=%h expected 0 0 0 0",
               fetch_hit, mem_req, busy, mem_addr);
    end
    tick();
    tick();
    rst_in      = 1'b1;
    fetch_valid = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1008);
    fetch_addr  = 32'h0000_1008;
    fetch_valid = 1'b1;
    #1;
    n_chk++;
    if (fetch_hit !== 1'b1 || fetch_data !== mem_word(32'h1008)) begin
      n_fail++;
      $display("FAIL cold_third: hit=%b data=%h expected 1 %h",
               fetch_hit, fetch_data, mem_word(32'h1008));
    end
    fetch_valid = 1'b0;
    tick();
    fetch(32'h0000_100C);
  endtask

  task automatic test_lru();
    test_reset();
    fetch(32'h1000);
    fetch(32'h2000);
    fetch(32'h1000);
    fetch(32'h3000);
    probe(32'h1000, 1'b1, "lru_keep_1000");
    probe(32'h2000, 1'b0, "lru_evict_2000");
    probe(32'h3004, 1'b1, "lru_new_3000");
  endtask

  task automatic test_flush_idle();
    test_reset();
    fetch(32'h1000);
    flush_idle(32'h1000);
    fetch(32'h1000);
  endtask

  task automatic test_flush_refill();
    test_reset();
    fetch_x(32'h1000, 2, -1);
    probe(32'h1000, 1'b0, "flush_refill_inval");
    fetch(32'h1000);
  endtask

  task automatic test_stall();
    test_reset();
    fetch_x(32'h1000, -1, 1);
    fetch(32'h1004);
    fetch(32'h1000);
    fetch(32'h100C);
  endtask

  task automatic test_async_reset();
    test_reset();
    fetch_valid = 1'b1;
    fetch_addr  = 32'h1000;
    tick();
    fetch_valid = 1'b0;
    mem_ack     = 1'b1;
    mem_data    = mem_word(32'h1000);
    tick();
    mem_ack = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b busy=%b expected 0 0", mem_req, busy);
    end
    tick();
    rst_in = 1'b1;
    model_clear();
    tick();
    probe(32'h1000, 1'b0, "async_reset_inval");
    fetch(32'h1000);
  endtask

  task automatic test_random();
    logic [31:0] a;
    test_reset();
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(1, 3)) << 12) | (32'($urandom_range(0, 3)) << 4)
        | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)
        flush_idle(a);
      else if ($urandom_range(0, 9) == 0)
        fetch_x(a, int'($urandom_range(1, 3)), -1);
      else
        fetch(a);
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_cold_miss();
    test_lru();
    test_flush_idle();
    test_flush_refill();
    test_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_cache_sa.md
Name: inst_cache_sa

Overview:
- Parametrised set-associative instruction cache with line-based refill, sitting between the IF stage and the memory controller.
- The fetch side does a same-cycle tag lookup. On a miss, a refill FSM pulls a full line from the memory controller one word at a time.
- Supports 1- or 2-way operation with per-set LRU, and a whole-cache invalidate (fence.i / flush).

Parameters:
- SET_BIT, 4, log2 of set count (sets = 1<<SET_BIT).
- LINE_WORD_BIT, 2, log2 of 32-bit words per line (default 4 words = 16 B).
- WAYS, 2, associativity; legal values 1 or 2.
- Derived: OFF = LINE_WORD_BIT+2; TAG_LEN = 32-SET_BIT-OFF.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global ready; low freezes all state.
- fetch_valid  in  1  IF stage is requesting an instruction.
- fetch_addr  in  32  fetch byte address; bits [1:0] are ignored.
- fetch_hit  out  1  fetch_data is valid this cycle.
- fetch_data  out  32  instruction word.
- flush  in  1  invalidate all lines (one-cycle pulse).
- busy  out  1  refill in progress.
- mem_req  out  1  word read request to the memory controller.
- mem_addr  out  32  word-aligned address of the word being requested.
- mem_ack  in  1  mem_data is valid for the current mem_addr.
- mem_data  in  32  returned word.

Behaviour:
- Address split: tag = addr[31:SET_BIT+OFF]; index = addr[SET_BIT+OFF-1:OFF]; word offset = addr[OFF-1:2].

Reset (asynchronous, rst_in=0):
- All valid bits 0; LRU bits 0; state IDLE.
- mem_req 0, mem_addr 0, word counter 0, flush_pending 0, busy 0.
- fetch_hit is 0 while in reset.

Lookup (combinational):
- fetch_hit = rdy_in & fetch_valid & state==IDLE & (some way valid with matching tag).
- fetch_data = the selected word of the hitting way; 0 when there is no hit.
- When fetch_hit is 1, the set's LRU is updated at the next edge to point away from the hit way (no-op when WAYS=1).

States:
- IDLE -> REFILL: fetch_valid & !hit & !flush.
  - At that edge: latch line base = {fetch_addr[31:OFF], OFF'b0}; latch index and tag.
  - Victim = lowest-index invalid way, otherwise the LRU way (way 0 if WAYS=1).
  - Counter = 0; mem_req=1; mem_addr = base.
- REFILL, on each edge with mem_ack:
  - Write mem_data into victim data[counter]; counter += 1; mem_addr += 4.
  - mem_req stays high between words.
- REFILL, on the edge with mem_ack and counter == last word:
  - Write the tag.
  - Set valid = !(flush_pending | flush).
  - Set LRU to point away from the victim.
  - mem_req=0; counter=0; flush_pending=0; state -> IDLE.
  - A fetch to the same line hits on the next cycle. Latency from miss to hit is (words + 1) cycles plus memory wait.
- busy = (state == REFILL).

Flush:
- In IDLE: all valid bits cleared at the next edge; the lookup that cycle is forced to miss and no refill starts.
- In REFILL: all valid bits cleared and flush_pending set. The refill runs to completion (the memory controller is never aborted) but the line is not marked valid.

Other rules:
- rdy_in=0: no state, counter, valid or LRU updates; mem_ack is ignored; mem_req and mem_addr hold their values; fetch_hit is 0. The memory controller must hold mem_ack until rdy_in is high.
- During REFILL, fetch_valid is ignored (no hits, no new misses). The IF stage retries after busy drops.
- Reset mid-refill: mem_req drops immediately (asynchronous); the partially filled line stays invalid.
- Misaligned fetch addresses are treated as word-aligned; this is not an error.

Test Plan (defaults: 16 sets, 4-word lines, 2 ways; index = addr[7:4]):
1. Cold miss:
   - Stimulus: reset, then fetch 0x00001008.
   - Required: mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C; busy high for the refill.
   - After the last ack: next cycle fetch_hit=1 with fetch_data = the third returned word; fetch 0x100C hits with the fourth word.
2. LRU replacement:
   - Stimulus: fill 0x1000, then 0x2000 (both set 0); hit 0x1000; then fetch 0x3000.
   - Required: the refill overwrites the 0x2000 way; afterwards 0x1000 hits and 0x2000 misses.
3. Flush in IDLE:
   - Stimulus: 0x1000 resident; assert flush together with fetch 0x1000.
   - Required: fetch_hit=0, no mem_req that cycle; the following fetch of 0x1000 misses and starts a refill.
4. Flush during refill:
   - Stimulus: pulse flush after the 2nd ack of the 0x1000 refill.
   - Required: all 4 words are still requested; busy drops; 0x1000 then misses again.
5. rdy_in stall:
   - Stimulus: drop rdy_in for 3 cycles after the 1st ack, holding mem_ack=1.
   - Required: mem_addr stays 0x1004 and the counter does not advance; fetch_hit=0; the refill resumes correctly.
6. Async reset mid-refill:
   - Stimulus: assert rst_in=0 between clock edges during a refill.
   - Required: mem_req and busy go to 0 immediately; after release, 0x1000 misses.
